// File: rtl/fpu_sequencer.sv
// Sequences multi-cycle FPU ops from EX: fixed per-op latency, pipeline stall, result capture for MEM/WB.
// Latency: result presented L cycles after accept; backpressure is the stall output, no input handshake.
module fpu_sequencer #(
    parameter int LAT_ADD     = 3,
    parameter int LAT_MADD    = 5,
    parameter int LAT_CVT     = 2,
    parameter int LAT_DEFAULT = 1,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  fpusel,
    input  logic [4:0]  op_fd,
    input  logic        flush,
    input  logic [31:0] fpu_result,
    output logic        fpu_start,
    output logic [2:0]  fpu_op,
    output logic        stall,
    output logic        res_valid,
    output logic [31:0] res_data,
    output logic [4:0]  res_fd,
    output logic        err,
    output logic [15:0] op_count
);

    // fpusel encodings shared with EX control
    localparam logic [2:0] FPU_ADD  = 3'd0;
    localparam logic [2:0] FPU_MADD = 3'd1;
    localparam logic [2:0] FPU_CVT  = 3'd2;
    localparam logic [2:0] FPU_SGNJ = 3'd3;
    localparam logic [2:0] FPU_ASEL = 3'd4;
    localparam logic [2:0] FPU_BSEL = 3'd5;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   counter, counter_nxt;
    logic [2:0]         op_q;
    logic [4:0]         fd_q;
    logic [CNT_W-1:0]   lat;
    logic               accept;
    logic               capture;
    logic               proto_err;

    function automatic logic [CNT_W-1:0] lat_of(input logic [2:0] sel);
        case (sel)
            FPU_ADD:  lat_of = CNT_W'(LAT_ADD);
            FPU_MADD: lat_of = CNT_W'(LAT_MADD);
            FPU_CVT:  lat_of = CNT_W'(LAT_CVT);
            default:  lat_of = CNT_W'(LAT_DEFAULT);
        endcase
    endfunction

    assign lat = lat_of(fpusel);

    always_comb begin
        state_nxt   = state;
        counter_nxt = counter;
        accept      = 1'b0;
        capture     = 1'b0;
        proto_err   = 1'b0;
        fpu_start   = 1'b0;
        fpu_op      = fpusel;
        stall       = 1'b0;
        if (state == IDLE) begin
            accept    = op_valid && !flush;
            fpu_start = accept;
            if (accept) begin
                if (lat > CNT_W'(1)) begin
                    state_nxt   = BUSY;
                    counter_nxt = lat - CNT_W'(2);
                    stall       = 1'b1;
                end else begin
                    capture = 1'b1;
                end
            end
        end else begin
            fpu_op    = op_q;
            // pipeline is released on the final (capture) cycle
            stall     = (counter != '0);
            proto_err = op_valid && !flush;
            if (counter == '0) begin
                state_nxt = IDLE;
                capture   = !flush;
            end else begin
                counter_nxt = counter - CNT_W'(1);
            end
        end
        if (flush) begin
            state_nxt   = IDLE;
            counter_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            counter   <= '0;
            op_q      <= '0;
            fd_q      <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_fd    <= '0;
            err       <= 1'b0;
            op_count  <= '0;
        end else begin
            state     <= state_nxt;
            counter   <= counter_nxt;
            res_valid <= capture;
            if (accept) begin
                op_q <= fpusel;
                fd_q <= op_fd;
            end
            if (capture) begin
                res_data <= fpu_result;
                // latency-1 ops capture in their accept cycle, before fd_q is loaded
                res_fd   <= accept ? op_fd : fd_q;
                op_count <= op_count + 16'd1;
            end
            if (proto_err)
                err <= 1'b1;
        end
    end

    // Encodings decoded only through the default latency arm
    logic unused_enc;
    assign unused_enc = ^{FPU_SGNJ, FPU_ASEL, FPU_BSEL};

endmodule
